// File: rtl/encoder_emu_mc.sv
// Multi-channel wheel-encoder emulator. Each channel produces a step
// every `period` clock cycles, advances a 2-bit Gray phase that drives
// the A/B lines, and tracks a signed, wrapping position count. A
// reconfiguration of a running channel is held in a shadow copy until
// the next step boundary, so the output pulses are never cut short or
// stretched.
module encoder_emu_mc #(
    parameter int NCH   = 2,
    parameter int CNT_W = 24,
    parameter int POS_W = 16,
    parameter int QUAD  = 0,
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [CNT_W-1:0]     cfg_period,
    input  logic                 cfg_dir,
    input  logic                 cfg_en,
    output logic [NCH-1:0]       evnt_a,
    output logic [NCH-1:0]       evnt_b,
    output logic [NCH-1:0]       step_stb,
    output logic [NCH*POS_W-1:0] pos
);

    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_11 = 2'b11,
        PH_10 = 2'b10
    } phase_t;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] sh_period;
        logic [CNT_W-1:0] ac_period;
        logic [CNT_W-1:0] cnt;
        logic             sh_dir;
        logic             sh_en;
        logic             ac_dir;
        logic             ac_en;
        phase_t           ph;
        phase_t           ph_nxt;
        logic [POS_W-1:0] pos_q;
        logic             stb_q;
        logic             idle;
        logic             boundary;
        logic             wr_hit;

        assign wr_hit   = cfg_we && (cfg_ch == CH_W'(i));
        assign idle     = !ac_en || (ac_period == '0);
        assign boundary = !idle && (cnt == '0);

        // Next Gray phase: full quadrature cycle, or a plain A toggle in single-line mode.
        always_comb begin
            ph_nxt = ph;
            if (QUAD != 0) begin
                case (ph)
                    PH_00:   ph_nxt = ac_dir ? PH_10 : PH_01;
                    PH_01:   ph_nxt = ac_dir ? PH_00 : PH_11;
                    PH_11:   ph_nxt = ac_dir ? PH_01 : PH_10;
                    PH_10:   ph_nxt = ac_dir ? PH_11 : PH_00;
                    default: ph_nxt = PH_00;
                endcase
            end else begin
                ph_nxt = (ph == PH_00) ? PH_10 : PH_00;
            end
        end

        // Channel state: step counting, boundary-aligned config hand-over, position.
        always_ff @(posedge Clk) begin
            if (Rst) begin
                sh_period <= '0;
                sh_dir    <= 1'b0;
                sh_en     <= 1'b0;
                ac_period <= '0;
                ac_dir    <= 1'b0;
                ac_en     <= 1'b0;
                cnt       <= '0;
                ph        <= PH_00;
                pos_q     <= '0;
                stb_q     <= 1'b0;
            end else begin
                stb_q <= boundary;
                if (boundary) begin
                    // The shadow is always current, so loading it unconditionally
                    // is the same as loading it only when it differs.
                    cnt       <= sh_period - CNT_W'(1);
                    ac_period <= sh_period;
                    ac_dir    <= sh_dir;
                    ac_en     <= sh_en;
                    ph        <= ph_nxt;
                    pos_q     <= ac_dir ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
                end else if (!idle) begin
                    cnt <= cnt - CNT_W'(1);
                end
                if (wr_hit) begin
                    sh_period <= cfg_period;
                    sh_dir    <= cfg_dir;
                    sh_en     <= cfg_en;
                    // An idle channel has no step in flight, so it starts at once.
                    if (idle) begin
                        ac_period <= cfg_period;
                        ac_dir    <= cfg_dir;
                        ac_en     <= cfg_en;
                        cnt       <= cfg_period - CNT_W'(1);
                    end
                end
            end
        end

        assign evnt_a[i]                = ph[1];
        assign evnt_b[i]                = (QUAD != 0) ? ph[0] : 1'b0;
        assign step_stb[i]              = stb_q;
        assign pos[i*POS_W +: POS_W]    = pos_q;
    end

endmodule

// File: doc/encoder_emu_mc.md
Name: encoder_emu_mc

Overview:
- Parametrised, synthesizable multi-channel wheel-encoder emulator.
- Successor to the fixed two-line `Evnt` toggle generator used for platform simulation.
- Provides per-channel runtime-programmable step period, direction, enable, optional quadrature A/B output and a signed position counter.
- Drives the motor-controller encoder inputs in simulation and in hardware-in-loop builds.

Parameters:
- NCH, 2, number of encoder channels (1..8).
- CNT_W, 24, width of the per-channel step-period counter.
- POS_W, 16, width of the per-channel signed position counter.
- QUAD, 0, 0 = single-line output (A only, B held 0); 1 = quadrature A/B.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous reset, active-high.
- cfg_we  in  1  configuration write strobe, one cycle.
- cfg_ch  in  $clog2(NCH) (min 1)  target channel.
- cfg_period  in  CNT_W  step period in Clk cycles; 0 = stopped.
- cfg_dir  in  1  0 = forward, 1 = reverse.
- cfg_en  in  1  channel enable.
- evnt_a  out  NCH  encoder line A per channel.
- evnt_b  out  NCH  encoder line B per channel (0 when QUAD=0).
- step_stb  out  NCH  one-cycle pulse per emitted step.
- pos  out  NCH*POS_W  signed position per channel, channel i at [i*POS_W +: POS_W].

Behaviour:

Reset (synchronous, `Rst`=1 at a Clk edge):
- All shadow and active registers go to 0: period, dir, en.
- Counters go to 0 and phase state goes to 00.
- `evnt_a`, `evnt_b`, `step_stb` and `pos` all go to 0.
- Reset asserted mid-step aborts the step; no strobe is issued.

Per-channel state:
- Shadow config {period, dir, en} and active config.
- Down counter `cnt`.
- 2-bit Gray phase `ph`.
- Position `pos`.

Configuration write:
- `cfg_we`=1 with `cfg_ch`<NCH loads that channel's shadow at the edge.
- `cfg_ch`>=NCH: the write is ignored.
- A channel is idle when active en=0 or active period=0.
- If the channel is idle at the write edge, active <= new config in the same edge and `cnt` <= new period-1.
- If the channel is running, active takes the shadow only at the next step boundary, so there are no runt or stretched pulses.
- Back-to-back writes to one channel: the last written shadow wins.

Stepping (running channel):
- Each cycle, `cnt` decrements.
- When `cnt`=0:
  - `step_stb` is 1 in the next cycle (registered).
  - `cnt` <= period-1, where period is taken from shadow if shadow differs from active.
  - Active <= shadow.
  - `ph` advances.
  - Period P gives one step every P cycles. P=1 steps every cycle.
- Forward sequence: 00→01→11→10→00. Reverse runs the same sequence backward.
- Output mapping:
  - QUAD=1: `evnt_a`=ph[1], `evnt_b`=ph[0]. A changes every 2 steps, so the A frequency is 1/(4P) of Clk.
  - QUAD=0: `ph` toggles between 00 and 10. `evnt_a` toggles every step (square wave of period 2P); `evnt_b`=0; `dir` affects only `pos`.
- `pos` increments (forward) or decrements (reverse) on each step.
- `pos` is two's-complement and wraps silently (0x7FFF+1 = 0x8000).

Disable and stop:
- Writing en=0 or period=0 to a running channel takes effect at the next boundary, via the normal shadow-to-active load at that boundary.
- After that the channel is idle: it holds `ph`, its outputs and `pos`, emits no strobe, and `cnt` holds.

Channels are fully independent. Simultaneous boundaries on several channels are all serviced in the same cycle.

Test Plan:
1. Reset, write ch0 {P=5, fwd, en} at cycle 10 (QUAD=1) -> `step_stb[0]` at cycles 15, 20, 25, 30; A/B = 01, 11, 10, 00 after each; `pos0` = 1, 2, 3, 4.
2. ch1 {P=3, rev, en}, 6 steps -> `pos1` = -6 (0xFFFA); B leads A (sequence 10, 11, 01, 00); ch0 unaffected while running concurrently.
3. Running ch0 at P=8; rewrite P=2 mid-count (`cnt`=5) -> the current step still lands 8 cycles after the previous one; later steps are 2 apart; no early strobe.
4. Write en=0 to a running channel, then reset pulse mid-count -> stepping stops at the next boundary with outputs held; after reset all outputs are 0 and no strobe occurs for ≥20 cycles.
5. QUAD=0, P=1 -> `evnt_a` toggles every cycle, `evnt_b`=0; preload to 0x7FFE, 2 steps -> `pos` = 0x7FFF then 0x8000.
6. Write with `cfg_ch`=NCH (out of range) and P=0 write -> no state change and the channel stays idle, respectively.
